// File: rtl/dual_issue_scheduler.sv
// Pair-issue controller: buffers one fetched instruction pair, checks intra-pair
// hazards, and issues the pair together or split over two cycles, oldest first.
module dual_issue_scheduler #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic [31:0]      fetch_instr0,
    input  logic [31:0]      fetch_instr1,
    input  logic             fetch_valid1,
    input  logic             issue_ready,
    output logic             issue0_valid,
    output logic [31:0]      issue0_instr,
    output logic [PC_W-1:0]  issue0_pc,
    output logic             issue1_valid,
    output logic [31:0]      issue1_instr,
    output logic [PC_W-1:0]  issue1_pc,
    input  logic             flush,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_HALF  = 2'd2
    } state_e;

    localparam logic [4:0] OP_STORE = 5'b10001;

    state_e            state_q, state_d;
    logic [31:0]       instr0_q, instr0_d;
    logic [31:0]       instr1_q, instr1_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid1_q, valid1_d;
    logic [CNT_W-1:0]  split_cnt_q, split_cnt_d;

    logic [4:0] op0, rd0, op1, rd1, rs1, rt1;
    logic       writes0, writes1, raw, waw, both_mem, both_ctrl, split_c;
    logic [PC_W-1:0] pc_plus4;
    logic       load;

    // Hazard decode on the buffered pair
    assign op0 = instr0_q[31:27];
    assign rd0 = instr0_q[26:22];
    assign op1 = instr1_q[31:27];
    assign rd1 = instr1_q[26:22];
    assign rs1 = instr1_q[21:17];
    assign rt1 = instr1_q[16:12];

    assign writes0   = (op0[4:3] != 2'b11) && (op0 != OP_STORE);
    assign writes1   = (op1[4:3] != 2'b11) && (op1 != OP_STORE);
    assign raw       = writes0 && (rd0 != 5'd0) && ((rd0 == rs1) || (rd0 == rt1));
    assign waw       = writes0 && writes1 && (rd0 != 5'd0) && (rd0 == rd1);
    assign both_mem  = (op0[4:3] == 2'b10) && (op1[4:3] == 2'b10);
    assign both_ctrl = (op0[4:3] == 2'b11) && (op1[4:3] == 2'b11);
    assign split_c   = valid1_q && (raw || waw || both_mem || both_ctrl);

    assign pc_plus4 = pc_q + PC_W'(4);

    assign fetch_ready = !flush && ((state_q == S_EMPTY) ||
                         (issue_ready && ((state_q == S_HALF) ||
                                          ((state_q == S_FULL) && !split_c))));
    assign load = fetch_valid && fetch_ready;

    // Presented slots come straight from state and buffer
    assign issue0_valid = (state_q != S_EMPTY);
    assign issue0_instr = (state_q == S_HALF) ? instr1_q : instr0_q;
    assign issue0_pc    = (state_q == S_HALF) ? pc_plus4 : pc_q;
    assign issue1_valid = (state_q == S_FULL) && valid1_q && !split_c;
    assign issue1_instr = instr1_q;
    assign issue1_pc    = pc_plus4;
    assign split_cnt    = split_cnt_q;

    always_comb begin
        state_d     = state_q;
        instr0_d    = instr0_q;
        instr1_d    = instr1_q;
        pc_d        = pc_q;
        valid1_d    = valid1_q;
        split_cnt_d = split_cnt_q;

        if (flush) begin
            state_d  = S_EMPTY;
            valid1_d = 1'b0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (load) state_d = S_FULL;
                end
                S_FULL: begin
                    if (issue_ready) begin
                        if (split_c) begin
                            state_d = S_HALF;
                            if (split_cnt_q != '1) split_cnt_d = split_cnt_q + CNT_W'(1);
                        end else begin
                            state_d = load ? S_FULL : S_EMPTY;
                        end
                    end
                end
                S_HALF: begin
                    if (issue_ready) state_d = load ? S_FULL : S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase

            if (load) begin
                instr0_d = fetch_instr0;
                instr1_d = fetch_instr1;
                pc_d     = fetch_pc;
                valid1_d = fetch_valid1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            instr0_q    <= '0;
            instr1_q    <= '0;
            pc_q        <= '0;
            valid1_q    <= 1'b0;
            split_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr0_q    <= instr0_d;
            instr1_q    <= instr1_d;
            pc_q        <= pc_d;
            valid1_q    <= valid1_d;
            split_cnt_q <= split_cnt_d;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: pair issue, hazard splits, stalls,
// flush, async reset mid-split and counter saturation.
module tb_dual_issue_scheduler;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [PC_W-1:0]  fetch_pc;
    logic [31:0]      fetch_instr0;
    logic [31:0]      fetch_instr1;
    logic             fetch_valid1;
    logic             issue_ready;
    logic             issue0_valid;
    logic [31:0]      issue0_instr;
    logic [PC_W-1:0]  issue0_pc;
    logic             issue1_valid;
    logic [31:0]      issue1_instr;
    logic [PC_W-1:0]  issue1_pc;
    logic             flush;
    logic [CNT_W-1:0] split_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    dual_issue_scheduler #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .fetch_valid1 (fetch_valid1),
        .issue_ready  (issue_ready),
        .issue0_valid (issue0_valid),
        .issue0_instr (issue0_instr),
        .issue0_pc    (issue0_pc),
        .issue1_valid (issue1_valid),
        .issue1_instr (issue1_instr),
        .issue1_pc    (issue1_pc),
        .flush        (flush),
        .split_cnt    (split_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one pair from EMPTY with issue_ready=1 and follow it until EMPTY again
    task automatic run_pair(input string tag, input logic [31:0] pc, input logic [31:0] i0,
                            input logic [31:0] i1, input logic v1, input logic exp_split);
        fetch_pc = pc; fetch_instr0 = i0; fetch_instr1 = i1; fetch_valid1 = v1;
        fetch_valid = 1'b1; issue_ready = 1'b1;
        #1 chk({tag, "_fr_empty"}, 64'(fetch_ready), 64'd1);
        step();
        fetch_valid = 1'b0;
        #1;
        chk({tag, "_i0v"},  64'(issue0_valid), 64'd1);
        chk({tag, "_i0"},   64'(issue0_instr), 64'(i0));
        chk({tag, "_i0pc"}, 64'(issue0_pc), 64'(pc));
        chk({tag, "_i1v"},  64'(issue1_valid), 64'(v1 && !exp_split));
        chk({tag, "_fr"},   64'(fetch_ready), 64'(!(v1 && exp_split)));
        if (v1 && !exp_split) chk({tag, "_i1pc"}, 64'(issue1_pc), 64'(pc + 32'd4));
        if (v1 && exp_split) begin
            exp_cnt++;
            step();
            #1;
            chk({tag, "_half_i0"},   64'(issue0_instr), 64'(i1));
            chk({tag, "_half_pc"},   64'(issue0_pc), 64'(pc + 32'd4));
            chk({tag, "_half_i1v"},  64'(issue1_valid), 64'd0);
            chk({tag, "_half_cnt"},  64'(split_cnt), 64'(exp_cnt));
        end
        step();
        #1 chk({tag, "_empty"}, 64'(issue0_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr0 = '0;
        fetch_instr1 = '0; fetch_valid1 = 1'b0; issue_ready = 1'b0; flush = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("por_fr",  64'(fetch_ready), 64'd1);
        chk("por_i0v", 64'(issue0_valid), 64'd0);
        chk("por_cnt", 64'(split_cnt), 64'd0);

        // 1. Async reset while in HALF
        @(negedge clk);
        fetch_pc = 32'h100; fetch_instr0 = mk(5'd0, 5'd3, 5'd1, 5'd2);
        fetch_instr1 = mk(5'd0, 5'd4, 5'd3, 5'd6); fetch_valid1 = 1'b1;
        fetch_valid = 1'b1; issue_ready = 1'b0;
        step();
        fetch_valid = 1'b0; issue_ready = 1'b1;
        step();
        #1;
        chk("t1_half_pc",  64'(issue0_pc), 64'h104);
        chk("t1_half_cnt", 64'(split_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_i0v", 64'(issue0_valid), 64'd0);
        chk("t1_rst_i1v", 64'(issue1_valid), 64'd0);
        chk("t1_rst_cnt", 64'(split_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t1_rel_fr", 64'(fetch_ready), 64'd1);

        // 2. Independent pairs back-to-back
        @(negedge clk);
        fetch_pc = 32'h100; fetch_instr0 = mk(5'd0, 5'd3, 5'd1, 5'd2);
        fetch_instr1 = mk(5'd0, 5'd4, 5'd5, 5'd6); fetch_valid1 = 1'b1;
        fetch_valid = 1'b1; issue_ready = 1'b1;
        step();
        fetch_pc = 32'h200; fetch_instr0 = mk(5'd0, 5'd7, 5'd8, 5'd9);
        fetch_instr1 = mk(5'd0, 5'd10, 5'd11, 5'd12);
        #1;
        chk("t2_i0v",  64'(issue0_valid), 64'd1);
        chk("t2_i0",   64'(issue0_instr), 64'(mk(5'd0, 5'd3, 5'd1, 5'd2)));
        chk("t2_i0pc", 64'(issue0_pc), 64'h100);
        chk("t2_i1v",  64'(issue1_valid), 64'd1);
        chk("t2_i1",   64'(issue1_instr), 64'(mk(5'd0, 5'd4, 5'd5, 5'd6)));
        chk("t2_i1pc", 64'(issue1_pc), 64'h104);
        chk("t2_fr",   64'(fetch_ready), 64'd1);
        step();
        fetch_valid = 1'b0;
        #1;
        chk("t2b_i0pc", 64'(issue0_pc), 64'h200);
        chk("t2b_i1v",  64'(issue1_valid), 64'd1);
        chk("t2b_i1pc", 64'(issue1_pc), 64'h204);
        step();
        #1 chk("t2_empty", 64'(issue0_valid), 64'd0);

        // 3/4. Hazard classes
        run_pair("raw",      32'h100, mk(5'd0, 5'd3, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd3, 5'd6), 1'b1, 1'b1);
        run_pair("raw_rt",   32'h300, mk(5'd0, 5'd9, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd5, 5'd9), 1'b1, 1'b1);
        run_pair("rd0",      32'h140, mk(5'd0, 5'd0, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd0, 5'd0), 1'b1, 1'b0);
        run_pair("waw",      32'h180, mk(5'd0, 5'd5, 5'd1, 5'd2), mk(5'd0, 5'd5, 5'd6, 5'd7), 1'b1, 1'b1);
        run_pair("stores",   32'h1c0, mk(5'b10001, 5'd9, 5'd1, 5'd2), mk(5'b10001, 5'd9, 5'd3, 5'd4), 1'b1, 1'b1);
        run_pair("ctrl2",    32'h200, mk(5'b11000, 5'd1, 5'd2, 5'd3), mk(5'b11010, 5'd4, 5'd5, 5'd6), 1'b1, 1'b1);
        run_pair("ctrl_nowr",32'h240, mk(5'b11000, 5'd3, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd3, 5'd6), 1'b1, 1'b0);
        run_pair("store_raw",32'h280, mk(5'b10001, 5'd3, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd3, 5'd6), 1'b1, 1'b0);
        run_pair("single",   32'h2c0, mk(5'd0, 5'd3, 5'd1, 5'd2), mk(5'd0, 5'd4, 5'd3, 5'd6), 1'b0, 1'b1);

        // 5. Split pair stalled three cycles
        fetch_pc = 32'h400; fetch_instr0 = mk(5'd0, 5'd3, 5'd1, 5'd2);
        fetch_instr1 = mk(5'd0, 5'd4, 5'd3, 5'd6); fetch_valid1 = 1'b1;
        fetch_valid = 1'b1; issue_ready = 1'b0;
        step();
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_hold_i0",  64'(issue0_instr), 64'(mk(5'd0, 5'd3, 5'd1, 5'd2)));
            chk("t5_hold_pc",  64'(issue0_pc), 64'h400);
            chk("t5_hold_i1v", 64'(issue1_valid), 64'd0);
            chk("t5_hold_fr",  64'(fetch_ready), 64'd0);
            chk("t5_hold_cnt", 64'(split_cnt), 64'(exp_cnt));
            step();
        end
        issue_ready = 1'b1;
        exp_cnt++;
        step();
        #1;
        chk("t5_half_i0",  64'(issue0_instr), 64'(mk(5'd0, 5'd4, 5'd3, 5'd6)));
        chk("t5_half_pc",  64'(issue0_pc), 64'h404);
        chk("t5_half_cnt", 64'(split_cnt), 64'(exp_cnt));

        // 6. Flush in HALF with a pair offered
        fetch_pc = 32'h500; fetch_instr0 = mk(5'd0, 5'd1, 5'd2, 5'd3);
        fetch_instr1 = mk(5'd0, 5'd4, 5'd5, 5'd6); fetch_valid1 = 1'b1;
        fetch_valid = 1'b1; flush = 1'b1;
        #1;
        chk("t6_flush_fr",  64'(fetch_ready), 64'd0);
        chk("t6_flush_i0v", 64'(issue0_valid), 64'd1);
        step();
        flush = 1'b0; fetch_valid = 1'b0;
        #1;
        chk("t6_i0v", 64'(issue0_valid), 64'd0);
        chk("t6_i1v", 64'(issue1_valid), 64'd0);
        chk("t6_cnt", 64'(split_cnt), 64'(exp_cnt));
        chk("t6_fr",  64'(fetch_ready), 64'd1);

        // Saturation: 2^CNT_W+3 back-to-back WAW splits
        fetch_pc = 32'h600; fetch_instr0 = mk(5'd0, 5'd5, 5'd1, 5'd2);
        fetch_instr1 = mk(5'd0, 5'd5, 5'd6, 5'd7); fetch_valid1 = 1'b1;
        fetch_valid = 1'b1; issue_ready = 1'b1;
        repeat (20) step();
        #1 chk("sat_mid", 64'(split_cnt), 64'(exp_cnt + 10));
        repeat (2 * ((1 << CNT_W) + 3) - 20) step();
        fetch_valid = 1'b0;
        step();
        #1;
        chk("sat_empty", 64'(issue0_valid), 64'd0);
        chk("sat_cnt",   64'(split_cnt), 64'((1 << CNT_W) - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
